call_queue: RTL
===============

# call_queue

Pending-call queue for the elevator controller: latches floor calls from the hall/cab buttons, suppresses duplicates, and presents the oldest outstanding call (`firstPosMem`, direction) to the queue comparator. The comparator reads the queue head; this block writes the calls and retires the head when the car reaches that floor. It sits between the button decoder and the comparator/motion FSM.

## Interface
- `DEPTH`, 8, number of call entries; power of two, ≥2
- `FLOOR_W`, 3, floor index width (floors 0..7)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `call_valid`  in  1  one-cycle strobe: new call on `floorCall`/`up_down_call`
- `floorCall`  in  FLOOR_W  requested floor
- `up_down_call`  in  1  requested direction, 1 = up, 0 = down
- `arrive`  in  1  one-cycle strobe: car stopped at `actualState`
- `actualState`  in  FLOOR_W  current car floor
- `firstPosMem`  out  FLOOR_W  head entry floor (0 when empty)
- `first_dir`  out  1  head entry direction (0 when empty)
- `head_valid`  out  1  queue non-empty
- `queue_full`  out  1  count == DEPTH
- `count`  out  $clog2(DEPTH)+1  entries held
- `overflow`  out  1  one-cycle pulse: call dropped because full
- `dup_drop`  out  1  one-cycle pulse: call dropped as duplicate

## Operation
- Circular buffer: entries {floor, dir}, write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrap modulo DEPTH; `count` tracked separately (distinguishes full/empty).
- Push: `call_valid` writes `{floorCall, up_down_call}` at `wp`, `wp` +1, `count` +1.
- Duplicate check: push suppressed, `dup_drop` pulses, if any valid entry (excluding one being popped same cycle) holds identical floor and dir. Same floor, opposite dir is a distinct call.
- Call to current floor: if `call_valid` and `arrive` same cycle with `floorCall == actualState`, call is treated as served: not pushed, no drop pulse.
- Pop: `arrive` with `head_valid` and `actualState == firstPosMem` retires head: `rp` +1, `count` -1. `arrive` at other floor: no change. Direction not compared for pop.
- Full: push with `count == DEPTH` and no same-cycle pop → dropped, `overflow` pulses. Push and pop same cycle while full → both performed, count stays DEPTH.
- Push and pop same cycle otherwise → count unchanged, both pointers advance.
- Empty: `arrive` ignored; `count` never underflows.
- Priority of checks on a push: served-at-current-floor, then duplicate, then full.

## Timing
- All outputs registered; reset values: `firstPosMem`=0, `first_dir`=0, `head_valid`=0, `queue_full`=0, `count`=0, `overflow`=0, `dup_drop`=0, pointers 0. Storage contents need no reset (masked by `count`).
- Push latency: call in cycle N visible on head outputs in cycle N+1 if queue was empty.
- Pop latency: head retired in cycle N; next entry (or empty values) on outputs in cycle N+1.
- Drop pulses high exactly the cycle after the offending strobe, for one cycle.
- `reset` mid-operation: queue emptied on that edge, all pending calls lost, strobes in reset cycle ignored.
- Strobes held high multiple cycles act as repeated requests (duplicate check absorbs repeats of a call).

## Structure
- Shared package `elevator_pkg`: `FLOOR_W`, `DIR_UP`/`DIR_DOWN` constants, `call_entry_t` packed struct {floor, dir}; comparator uses same types.
- One sub-module natural: `call_match`, combinational DEPTH-wide compare of an entry against valid buffer slots (valid mask from `rp`/`count`), returns hit; reusable by the comparator.
- Top holds pointers, count, storage, output registers.

## Test plan
- Reset, push {3,up}, {5,down}, {1,up} → head {3,up}, count 3; `arrive` at 3 → head {5,down}, count 2.
- Push {4,up} twice, then {4,down} → count 2, `dup_drop` once after second push.
- Fill 8 distinct calls, push 9th → `overflow` pulse, count 8; then push + pop-head same cycle → count 8, new call at tail.
- Wrap: 12 push/pop cycles across pointer wrap → FIFO order preserved, head matches expected model every cycle.
- `call_valid` {2,up} with `arrive` at 2 on empty queue → nothing stored, no pulses; `arrive` at 6 with head 3 → no change.
- Assert `reset` with 5 entries mid-stream → next cycle all outputs zero, subsequent push behaves as from empty.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the elevator call path.
// Used by call_queue, call_match and the queue comparator so that all of
// them agree on the floor width, the direction encoding and the entry layout.
package elevator_pkg;

  localparam int FLOOR_W = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic [FLOOR_W-1:0] floor;
    logic               dir;
  } call_entry_t;

endpackage

// File: rtl/call_queue_if.sv
// Call queue bus: button-decoder / car-position inputs and queue-head status.
//   master : drives call_valid, floorCall, up_down_call, arrive, actualState;
//            observes firstPosMem, first_dir, head_valid, queue_full, count,
//            overflow, dup_drop
//   slave  : the call queue itself (opposite directions)
interface call_queue_if
  import elevator_pkg::*;
#(
  parameter int DEPTH = 8
) ();

  logic                     call_valid;
  logic [FLOOR_W-1:0]       floorCall;
  logic                     up_down_call;
  logic                     arrive;
  logic [FLOOR_W-1:0]       actualState;

  logic [FLOOR_W-1:0]       firstPosMem;
  logic                     first_dir;
  logic                     head_valid;
  logic                     queue_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     dup_drop;

  modport master (
    output call_valid, floorCall, up_down_call, arrive, actualState,
    input  firstPosMem, first_dir, head_valid, queue_full, count,
           overflow, dup_drop
  );

  modport slave (
    input  call_valid, floorCall, up_down_call, arrive, actualState,
    output firstPosMem, first_dir, head_valid, queue_full, count,
           overflow, dup_drop
  );

endinterface

// File: rtl/call_queue_match.sv
// call_match: combinational search of a circular call buffer.
//   entries : buffer storage (DEPTH slots)
//   rp      : index of the oldest valid slot
//   cnt     : number of valid slots starting at rp (wrapping)
//   probe   : entry to look for
//   hit     : 1 when some valid slot equals probe (floor and direction)
module call_match
  import elevator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  call_entry_t               entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  rp,
  input  logic [$clog2(DEPTH):0]    cnt,
  input  call_entry_t               probe,
  output logic                      hit
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] in_window;

  always_comb begin
    in_window = '0;
    hit       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // Distance of slot i from the head, modulo DEPTH; valid if it lies
      // inside the occupied window.
      in_window[i] = ({1'b0, PW'(PW'(i) - rp)} < cnt);
      if (in_window[i] && (entries[i] == probe)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_queue.sv
// call_queue: pending floor-call FIFO with duplicate suppression.
// Latches calls from the button decoder, drops repeats of an outstanding
// call, and presents the oldest call to the comparator. The head is retired
// when the car stops at the head's floor.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : call_queue_if slave (call strobe/floor/dir, arrive/position in;
//            head floor/dir, head_valid, queue_full, count, overflow and
//            dup_drop pulses out; all outputs registered)
module call_queue
  import elevator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  call_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  call_entry_t     mem_q [DEPTH];

  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;

  call_entry_t     head_q, head_d;
  logic            head_valid_q, head_valid_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            dup_q, dup_d;

  call_entry_t     new_entry;
  call_entry_t     head_entry;
  logic            served;
  logic            pop;
  logic            push;
  logic            hit;
  logic [PW-1:0]   match_rp;
  logic [CW-1:0]   match_cnt;

  always_comb begin
    new_entry  = '{floor: bus.floorCall, dir: bus.up_down_call};
    head_entry = mem_q[rp_q];

    // A call for the floor the car is stopping at is satisfied immediately.
    served = bus.call_valid && bus.arrive && (bus.floorCall == bus.actualState);

    pop = bus.arrive && (count_q != '0) && (bus.actualState == head_entry.floor);

    // The head being retired this cycle no longer counts as outstanding.
    match_rp  = pop ? PW'(rp_q + PW'(1)) : rp_q;
    match_cnt = pop ? CW'(count_q - CW'(1)) : count_q;
  end

  call_match #(.DEPTH(DEPTH)) u_match (
    .entries (mem_q),
    .rp      (match_rp),
    .cnt     (match_cnt),
    .probe   (new_entry),
    .hit     (hit)
  );

  always_comb begin
    push  = bus.call_valid && !served && !hit && ((count_q != FULL_CNT) || pop);
    ovf_d = bus.call_valid && !served && !hit && (count_q == FULL_CNT) && !pop;
    dup_d = bus.call_valid && !served && hit;

    wp_d = push ? PW'(wp_q + PW'(1)) : wp_q;
    rp_d = pop  ? PW'(rp_q + PW'(1)) : rp_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = CW'(count_q + CW'(1));
    end else if (pop && !push) begin
      count_d = CW'(count_q - CW'(1));
    end

    // Next head: an already stored entry if anything survives the pop,
    // otherwise the entry being pushed into an (effectively) empty queue.
    head_d = '0;
    if (match_cnt != '0) begin
      head_d = mem_q[rp_d];
    end else if (push) begin
      head_d = new_entry;
    end

    head_valid_d = (count_d != '0);
    full_d       = (count_d == FULL_CNT);
  end

  // Storage is not reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wp_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      dup_q        <= dup_d;
    end
  end

  assign bus.firstPosMem = head_q.floor;
  assign bus.first_dir   = head_q.dir;
  assign bus.head_valid  = head_valid_q;
  assign bus.queue_full  = full_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.dup_drop    = dup_q;

endmodule
